// File: rtl/rbot_moves_pkg.sv
// Move codes, validity/inverse helpers and packer state encoding shared by the
// move-loading producer and its consumers (sequencer, move_to_step).
package rbot_moves_pkg;

  localparam int MOVE_W = 4;

  localparam logic [MOVE_W-1:0] MOVE_R  = 4'd2;
  localparam logic [MOVE_W-1:0] MOVE_RI = 4'd3;
  localparam logic [MOVE_W-1:0] MOVE_U  = 4'd4;
  localparam logic [MOVE_W-1:0] MOVE_UI = 4'd5;
  localparam logic [MOVE_W-1:0] MOVE_F  = 4'd6;
  localparam logic [MOVE_W-1:0] MOVE_FI = 4'd7;
  localparam logic [MOVE_W-1:0] MOVE_L  = 4'd8;
  localparam logic [MOVE_W-1:0] MOVE_LI = 4'd9;
  localparam logic [MOVE_W-1:0] MOVE_B  = 4'd10;
  localparam logic [MOVE_W-1:0] MOVE_BI = 4'd11;
  localparam logic [MOVE_W-1:0] MOVE_D  = 4'd12;
  localparam logic [MOVE_W-1:0] MOVE_DI = 4'd13;

  localparam logic [2:0] ST_ACCEPT   = 3'd0;
  localparam logic [2:0] ST_EMIT     = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_FINISHED = 3'd4;

  function automatic logic is_valid_move(input logic [MOVE_W-1:0] m);
    return (m >= 4'd2) && (m <= 4'd13);
  endfunction

  // Face lives in bits [3:1]; bit 0 selects the inverse turn.
  function automatic logic is_inverse_pair(input logic [MOVE_W-1:0] a,
                                           input logic [MOVE_W-1:0] b);
    return is_valid_move(a) && is_valid_move(b) &&
           (a[3:1] == b[3:1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/move_list_packer.sv
// Packs accepted move codes into fixed-size batches for the sequencer,
// optionally cancelling a move that is immediately undone by its inverse.
module move_list_packer
  import rbot_moves_pkg::*;
#(
  parameter int MAX_MOVES  = 50,
  parameter int GAP_CYCLES = 4,
  parameter bit CANCEL_EN  = 1'b1
) (
  input  logic                          clock_25mhz,
  input  logic                          reset,
  input  logic [MOVE_W-1:0]             move_in,
  input  logic                          move_valid,
  input  logic                          move_last,
  output logic                          move_ready,
  output logic [MOVE_W*MAX_MOVES-1:0]   seq,
  output logic                          new_moves,
  output logic                          seq_complete,
  output logic [7:0]                    num_moves,
  output logic [7:0]                    batch_count,
  output logic                          invalid_seen
);

  localparam int         SEQ_W = MOVE_W * MAX_MOVES;
  localparam logic [7:0] MAX_N = 8'(MAX_MOVES);
  localparam logic [7:0] GAP_N = 8'(GAP_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [SEQ_W-1:0] pack_q, pack_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       batch_q, batch_d;
  logic [7:0]       gap_q, gap_d;
  logic             new_moves_q, new_moves_d;
  logic             seq_complete_q, seq_complete_d;
  logic             invalid_q, invalid_d;
  logic             pending_last_q, pending_last_d;
  logic             accept_s;
  logic             cancel_s;

  assign move_ready = (state_q == ST_ACCEPT);
  assign accept_s   = move_valid && move_ready;
  assign cancel_s   = (CANCEL_EN != 1'b0) && (num_q != 8'd0) &&
                      is_inverse_pair(pack_q[MOVE_W-1:0], move_in);

  // Next-state and datapath update for the packing FSM.
  always_comb begin
    state_d        = state_q;
    pack_d         = pack_q;
    seq_d          = seq_q;
    num_d          = num_q;
    batch_d        = batch_q;
    gap_d          = gap_q;
    new_moves_d    = 1'b0;
    seq_complete_d = 1'b0;
    invalid_d      = invalid_q;
    pending_last_d = pending_last_q;
    case (state_q)
      ST_ACCEPT: begin
        if (accept_s) begin
          if (!is_valid_move(move_in)) begin
            invalid_d = 1'b1;
          end else if (cancel_s) begin
            pack_d = {{MOVE_W{1'b0}}, pack_q[SEQ_W-1:MOVE_W]};
            num_d  = num_q - 8'd1;
          end else begin
            pack_d = {pack_q[SEQ_W-MOVE_W-1:0], move_in};
            num_d  = num_q + 8'd1;
          end
          // A full batch always flushes first; a pending last then ends the list after the gap.
          if (num_d == MAX_N) begin
            state_d        = ST_EMIT;
            pending_last_d = move_last;
          end else if (move_last) begin
            state_d        = (num_d != 8'd0) ? ST_EMIT : ST_DONE;
            pending_last_d = 1'b1;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_EMIT: begin
        seq_d       = pack_q;
        new_moves_d = 1'b1;
        pack_d      = {SEQ_W{1'b0}};
        num_d       = 8'd0;
        batch_d     = (batch_q == 8'hFF) ? batch_q : batch_q + 8'd1;
        gap_d       = GAP_N;
        state_d     = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = pending_last_q ? ST_DONE : ST_ACCEPT;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_DONE: begin
        seq_complete_d = 1'b1;
        state_d        = ST_FINISHED;
      end
      ST_FINISHED: begin
        state_d = ST_FINISHED;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      state_q        <= ST_ACCEPT;
      pack_q         <= {SEQ_W{1'b0}};
      seq_q          <= {SEQ_W{1'b0}};
      num_q          <= 8'd0;
      batch_q        <= 8'd0;
      gap_q          <= 8'd0;
      new_moves_q    <= 1'b0;
      seq_complete_q <= 1'b0;
      invalid_q      <= 1'b0;
      pending_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pack_q         <= pack_d;
      seq_q          <= seq_d;
      num_q          <= num_d;
      batch_q        <= batch_d;
      gap_q          <= gap_d;
      new_moves_q    <= new_moves_d;
      seq_complete_q <= seq_complete_d;
      invalid_q      <= invalid_d;
      pending_last_q <= pending_last_d;
    end
  end

  assign seq          = seq_q;
  assign new_moves    = new_moves_q;
  assign seq_complete = seq_complete_q;
  assign num_moves    = num_q;
  assign batch_count  = batch_q;
  assign invalid_seen = invalid_q;

endmodule
